// File: rtl/delay_engine.sv
// delay_engine: per-sample sequencer for the delay pedal.
// One accepted step runs a frame: ADC capture, delayed-sample RAM read, wet/dry/feedback
// mix, RAM write-back, DAC write and write-pointer advance. Handshakes use 1-cycle req/done pulses.
module delay_engine #(
  parameter int          SAMPLE_W = 16,
  parameter int          GAIN_W   = 8,
  parameter int          DEPTH    = 65536,
  parameter logic [23:0] RAM_BASE = 24'h0
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                step,
  input  logic [23:0]         delay_len,
  input  logic [GAIN_W-1:0]   fb_gain,
  input  logic [GAIN_W-1:0]   mix_gain,
  input  logic                bypass,
  output logic                adc_req,
  input  logic                adc_done,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic                ram_req,
  output logic                ram_we,
  output logic [23:0]         ram_addr,
  output logic [SAMPLE_W-1:0] ram_wdata,
  input  logic                ram_done,
  input  logic [SAMPLE_W-1:0] ram_rdata,
  output logic                dac_req,
  output logic [SAMPLE_W-1:0] dac_data,
  input  logic                dac_done,
  output logic                busy,
  output logic                overrun
);

  localparam int                   PW      = SAMPLE_W + GAIN_W + 2;
  localparam logic [23:0]          BYTES   = 24'(SAMPLE_W / 8);
  localparam logic [23:0]          DEPTH_V = 24'(DEPTH);
  localparam logic [23:0]          DMAX    = 24'(DEPTH - 1);
  localparam logic [SAMPLE_W-1:0]  MSB     = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [PW-1:0] UNITY   = {{(PW-GAIN_W-1){1'b0}}, 1'b1, {GAIN_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ADC = 3'd1, S_RD = 3'd2, S_MIX = 3'd3,
    S_WR   = 3'd4, S_DAC = 3'd5, S_ADV = 3'd6
  } state_t;

  // Saturate a wide signed value into the sample range.
  function automatic logic [SAMPLE_W-1:0] sat_f(input logic signed [PW-1:0] v);
    logic [PW-SAMPLE_W:0] hi;
    hi = v[PW-1:SAMPLE_W-1];
    if ((hi == {(PW-SAMPLE_W+1){1'b0}}) || (hi == {(PW-SAMPLE_W+1){1'b1}})) begin
      sat_f = v[SAMPLE_W-1:0];
    end else if (v[PW-1]) begin
      sat_f = MSB;
    end else begin
      sat_f = ~MSB;
    end
  endfunction

  // Clamp the requested delay into the usable buffer range [1, DEPTH-1].
  function automatic logic [23:0] clamp_f(input logic [23:0] len);
    if (len == 24'd0) begin
      clamp_f = 24'd1;
    end else if (len > DMAX) begin
      clamp_f = DMAX;
    end else begin
      clamp_f = len;
    end
  endfunction

  state_t              state_q, state_d;
  logic [23:0]         w_ptr_q, w_ptr_d, d_q, d_d;
  logic [GAIN_W-1:0]   fb_q, fb_d, mix_q, mix_d;
  logic                byp_q, byp_d;
  logic [SAMPLE_W-1:0] dry_q, dry_d, wet_q, wet_d, out_q, out_d;
  logic                adc_req_q, adc_req_d, ram_req_q, ram_req_d, ram_we_q, ram_we_d;
  logic [23:0]         ram_addr_q, ram_addr_d;
  logic [SAMPLE_W-1:0] ram_wdata_q, ram_wdata_d, dac_data_q, dac_data_d;
  logic                dac_req_q, dac_req_d, busy_q, busy_d, overrun_q, overrun_d;

  logic [23:0]         rd_ptr_s;
  logic signed [PW-1:0] dry_e_s, wet_e_s, mix_e_s, fb_e_s, inv_e_s;
  logic signed [PW-1:0] mix_acc_s, mix_sh_s, fb_prod_s, fbk_sum_s;

  // Read pointer trails the write pointer by the latched delay, wrapping without underflow.
  always_comb begin
    rd_ptr_s = 24'd0;
    if (w_ptr_q < d_q) begin
      rd_ptr_s = w_ptr_q + DEPTH_V - d_q;
    end else begin
      rd_ptr_s = w_ptr_q - d_q;
    end
  end

  // Signed mix arithmetic on the captured dry/wet samples and latched gains.
  always_comb begin
    dry_e_s   = {{(PW-SAMPLE_W){dry_q[SAMPLE_W-1]}}, dry_q};
    wet_e_s   = {{(PW-SAMPLE_W){wet_q[SAMPLE_W-1]}}, wet_q};
    mix_e_s   = {{(PW-GAIN_W){1'b0}}, mix_q};
    fb_e_s    = {{(PW-GAIN_W){1'b0}}, fb_q};
    inv_e_s   = UNITY - mix_e_s;
    mix_acc_s = (dry_e_s * inv_e_s) + (wet_e_s * mix_e_s);
    mix_sh_s  = mix_acc_s >>> GAIN_W;
    fb_prod_s = wet_e_s * fb_e_s;
    fbk_sum_s = dry_e_s + (fb_prod_s >>> GAIN_W);
  end

  // Frame sequencer next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    w_ptr_d     = w_ptr_q;
    d_d         = d_q;
    fb_d        = fb_q;
    mix_d       = mix_q;
    byp_d       = byp_q;
    dry_d       = dry_q;
    wet_d       = wet_q;
    out_d       = out_q;
    adc_req_d   = 1'b0;
    ram_req_d   = 1'b0;
    dac_req_d   = 1'b0;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    dac_data_d  = dac_data_q;
    if (step && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
    case (state_q)
      S_IDLE: begin
        if (step) begin
          state_d   = S_ADC;
          adc_req_d = 1'b1;
          d_d       = clamp_f(delay_len);
          fb_d      = fb_gain;
          mix_d     = mix_gain;
          byp_d     = bypass;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADC: begin
        if (adc_done) begin
          dry_d      = adc_data ^ MSB;
          state_d    = S_RD;
          ram_req_d  = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = RAM_BASE + (BYTES * rd_ptr_s);
        end else begin
          state_d = S_ADC;
        end
      end
      S_RD: begin
        if (ram_done) begin
          wet_d   = ram_rdata;
          state_d = S_MIX;
        end else begin
          state_d = S_RD;
        end
      end
      S_MIX: begin
        out_d       = sat_f(mix_sh_s);
        ram_wdata_d = sat_f(fbk_sum_s);
        state_d     = S_WR;
        ram_req_d   = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = RAM_BASE + (BYTES * w_ptr_q);
      end
      S_WR: begin
        if (ram_done) begin
          state_d    = S_DAC;
          dac_req_d  = 1'b1;
          dac_data_d = (byp_q ? dry_q : out_q) ^ MSB;
        end else begin
          state_d = S_WR;
        end
      end
      S_DAC: begin
        if (dac_done) begin
          state_d = S_ADV;
        end else begin
          state_d = S_DAC;
        end
      end
      S_ADV: begin
        w_ptr_d = (w_ptr_q == DMAX) ? 24'd0 : (w_ptr_q + 24'd1);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      w_ptr_q     <= 24'd0;
      d_q         <= 24'd1;
      fb_q        <= {GAIN_W{1'b0}};
      mix_q       <= {GAIN_W{1'b0}};
      byp_q       <= 1'b0;
      dry_q       <= {SAMPLE_W{1'b0}};
      wet_q       <= {SAMPLE_W{1'b0}};
      out_q       <= {SAMPLE_W{1'b0}};
      adc_req_q   <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 24'd0;
      ram_wdata_q <= {SAMPLE_W{1'b0}};
      dac_req_q   <= 1'b0;
      dac_data_q  <= {SAMPLE_W{1'b0}};
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_ptr_q     <= w_ptr_d;
      d_q         <= d_d;
      fb_q        <= fb_d;
      mix_q       <= mix_d;
      byp_q       <= byp_d;
      dry_q       <= dry_d;
      wet_q       <= wet_d;
      out_q       <= out_d;
      adc_req_q   <= adc_req_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      dac_req_q   <= dac_req_d;
      dac_data_q  <= dac_data_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign adc_req   = adc_req_q;
  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign dac_req   = dac_req_q;
  assign dac_data  = dac_data_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_delay_engine.sv
// Bench for delay_engine: a sample-level model of the delay line predicts every RAM access
// and DAC code per frame; handshake responders emulate ADC, SPI RAM and DAC.
module tb_delay_engine;

  localparam int          DEPTH = 8;
  localparam logic [23:0] BASE  = 24'h000100;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        step = 1'b0;
  logic [23:0] delay_len = 24'd1;
  logic [7:0]  fb_gain = 8'd0, mix_gain = 8'd0;
  logic        bypass = 1'b0;
  logic        adc_req, ram_req, ram_we, dac_req, busy, overrun;
  logic [23:0] ram_addr;
  logic [15:0] ram_wdata, dac_data;
  logic [15:0] adc_data = 16'h0000, ram_rdata = 16'h0000;
  logic        adc_done_r = 1'b0, ram_done_r = 1'b0, dac_done_r = 1'b0;
  logic        spur_adc = 1'b0, spur_ram = 1'b0, spur_dac = 1'b0;
  logic        adc_done, ram_done, dac_done;

  assign adc_done = adc_done_r | spur_adc;
  assign ram_done = ram_done_r | spur_ram;
  assign dac_done = dac_done_r | spur_dac;

  delay_engine #(.SAMPLE_W(16), .GAIN_W(8), .DEPTH(DEPTH), .RAM_BASE(BASE)) dut (
    .clk(clk), .nrst(nrst), .step(step), .delay_len(delay_len), .fb_gain(fb_gain),
    .mix_gain(mix_gain), .bypass(bypass), .adc_req(adc_req), .adc_done(adc_done),
    .adc_data(adc_data), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_done(ram_done), .ram_rdata(ram_rdata), .dac_req(dac_req),
    .dac_data(dac_data), .dac_done(dac_done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int dac_cnt = 0;
  logic [15:0] adc_next = 16'h0000;
  logic [15:0] mem [int];
  logic [15:0] model_ram [DEPTH];
  int m_wptr = 0;
  int saved_idx = 0;
  logic [15:0] saved_val = 16'h0000;
  int exp_rd_q[$], exp_wr_q[$], exp_wd_q[$], exp_dac_q[$];
  logic [23:0] last_rd_addr = 24'd0, last_wr_addr = 24'd0;
  logic [15:0] last_wdata = 16'd0, last_dac = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int fdiv(input int v);
    if (v >= 0) return v / 256;
    else return -((-v + 255) / 256);
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
  endfunction

  // Model one frame at step acceptance: what the RAM and DAC must see.
  task automatic predict(input logic [15:0] sample, input logic [23:0] dl, input logic [7:0] fb,
                         input logic [7:0] mix, input logic byp);
    int d, rd, dry, wet, o, f, mi, fi, dv;
    logic [15:0] w16;
    mi = mix;
    fi = fb;
    if (dl == 24'd0) d = 1;
    else if (dl > 24'(DEPTH - 1)) d = DEPTH - 1;
    else d = int'(dl);
    rd  = (m_wptr - d + DEPTH) % DEPTH;
    dry = int'(sample) - 32768;
    w16 = model_ram[rd];
    wet = (int'(w16) >= 32768) ? int'(w16) - 65536 : int'(w16);
    o   = sat16(fdiv(dry * (256 - mi) + wet * mi));
    f   = sat16(dry + fdiv(wet * fi));
    dv  = ((byp ? dry : o) + 32768) % 65536;
    exp_rd_q.push_back(int'(BASE) + 2 * rd);
    exp_wr_q.push_back(int'(BASE) + 2 * m_wptr);
    exp_wd_q.push_back((f + 65536) % 65536);
    exp_dac_q.push_back(dv);
    saved_idx = m_wptr;
    saved_val = model_ram[m_wptr];
    model_ram[m_wptr] = 16'((f + 65536) % 65536);
    m_wptr = (m_wptr + 1) % DEPTH;
  endtask

  task automatic flush_model(input logic restore);
    if (restore) model_ram[saved_idx] = saved_val;
    m_wptr = 0;
    exp_rd_q.delete(); exp_wr_q.delete(); exp_wd_q.delete(); exp_dac_q.delete();
  endtask

  task automatic set_ram(input int idx, input logic [15:0] v);
    mem[int'(BASE) + 2 * idx] = v;
    model_ram[idx] = v;
  endtask

  // ADC responder.
  initial forever begin
    @(posedge clk); #1;
    if (nrst && adc_req) begin
      repeat (3) @(posedge clk);
      #1;
      if (nrst) begin
        adc_data = adc_next; adc_done_r = 1'b1;
        @(posedge clk); #1; adc_done_r = 1'b0;
      end
    end
  end

  // SPI RAM responder.
  initial forever begin
    logic r_we; logic [23:0] r_addr; logic [15:0] r_wd;
    @(posedge clk); #1;
    if (nrst && ram_req) begin
      r_we = ram_we; r_addr = ram_addr; r_wd = ram_wdata;
      repeat (2) @(posedge clk);
      #1;
      if (nrst) begin
        if (r_we) mem[int'(r_addr)] = r_wd;
        else ram_rdata = mem.exists(int'(r_addr)) ? mem[int'(r_addr)] : 16'h0000;
        ram_done_r = 1'b1;
        @(posedge clk); #1; ram_done_r = 1'b0;
      end
    end
  end

  // DAC responder.
  initial forever begin
    @(posedge clk); #1;
    if (nrst && dac_req) begin
      repeat (2) @(posedge clk);
      #1;
      if (nrst) begin
        dac_done_r = 1'b1;
        @(posedge clk); #1; dac_done_r = 1'b0;
      end
    end
  end

  // Compare process: every request pulse is checked against the model's expectations.
  initial begin
    logic p_adc, p_ram, p_dac;
    p_adc = 1'b0; p_ram = 1'b0; p_dac = 1'b0;
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (adc_req) chk("adc_req_one_cycle", {31'd0, p_adc}, 32'd0);
        if (ram_req) begin
          chk("ram_req_one_cycle", {31'd0, p_ram}, 32'd0);
          if (!ram_we) begin
            last_rd_addr = ram_addr;
            chk("rd_expected", {31'd0, exp_rd_q.size() != 0}, 32'd1);
            if (exp_rd_q.size() != 0) chk("rd_addr", ram_addr, exp_rd_q.pop_front());
          end else begin
            last_wr_addr = ram_addr;
            last_wdata = ram_wdata;
            chk("wr_expected", {31'd0, exp_wr_q.size() != 0}, 32'd1);
            if (exp_wr_q.size() != 0) begin
              chk("wr_addr", ram_addr, exp_wr_q.pop_front());
              chk("wr_data", ram_wdata, exp_wd_q.pop_front());
            end
          end
        end
        if (dac_req) begin
          dac_cnt++;
          last_dac = dac_data;
          chk("dac_req_one_cycle", {31'd0, p_dac}, 32'd0);
          chk("dac_expected", {31'd0, exp_dac_q.size() != 0}, 32'd1);
          if (exp_dac_q.size() != 0) chk("dac_data", dac_data, exp_dac_q.pop_front());
        end
      end
      p_adc = adc_req; p_ram = ram_req; p_dac = dac_req;
    end
  end

  task automatic do_reset();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    flush_model(1'b0);
  endtask

  task automatic start_frame(input logic [15:0] s, input logic [23:0] dl, input logic [7:0] fb,
                             input logic [7:0] mix, input logic byp);
    adc_next = s; delay_len = dl; fb_gain = fb; mix_gain = mix; bypass = byp;
    predict(s, dl, fb, mix, byp);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    delay_len = 24'($urandom); fb_gain = 8'($urandom); mix_gain = 8'($urandom);
    bypass = 1'($urandom);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 200) begin
      @(posedge clk); #1; c++;
    end
    chk("frame_timeout", {31'd0, c >= 200}, 32'd0);
  endtask

  task automatic do_frame(input logic [15:0] s, input logic [23:0] dl, input logic [7:0] fb,
                          input logic [7:0] mix, input logic byp);
    int dc0;
    dc0 = dac_cnt;
    start_frame(s, dl, fb, mix, byp);
    wait_idle();
    chk("dac_pulses_per_frame", dac_cnt - dc0, 32'd1);
    chk("queues_drained", exp_rd_q.size() + exp_wr_q.size() + exp_dac_q.size(), 32'd0);
  endtask

  task automatic wait_ram(input logic we);
    int c = 0;
    while (!(ram_req && (ram_we == we)) && c < 100) begin
      @(posedge clk); #1; c++;
    end
    chk("wait_ram_timeout", {31'd0, c >= 100}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_ram[i] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    // Reset state.
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_reqs", {29'd0, adc_req, ram_req, dac_req}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_dac_data", dac_data, 32'd0);

    // Stray done pulses while idle are ignored.
    spur_adc = 1'b1; spur_ram = 1'b1; spur_dac = 1'b1;
    @(posedge clk); #1;
    spur_adc = 1'b0; spur_ram = 1'b0; spur_dac = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("spurious_done_idle", {31'd0, busy}, 32'd0);

    // Straight-through frame, then pointer advance.
    do_frame(16'h8123, 24'd1, 8'd0, 8'd0, 1'b0);
    chk("t1_dac", last_dac, 32'h8123);
    chk("t1_wr_addr", last_wr_addr, BASE);
    chk("t1_wdata", last_wdata, 32'h0123);
    do_frame(16'h7000, 24'd1, 8'd0, 8'd0, 1'b0);
    chk("t1_wptr_advanced", last_wr_addr, BASE + 24'd2);

    // Delay of 3 with full wet mix over a ramp.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      do_frame(16'(32'h8100 + 32'h100 * k), 24'd3, 8'd0, 8'd255, 1'b0);
      if (k == 0) chk("t2_first_rd_addr", last_rd_addr, BASE + 24'd10);
      if (k == 3) chk("t2_dac_frame3", last_dac, 32'h8103);
    end

    // Saturation of the feedback path, and bypass.
    do_reset();
    set_ram(7, 16'h7FFF);
    do_frame(16'hFFFF, 24'd1, 8'd255, 8'd128, 1'b0);
    chk("t3_sat_pos", last_wdata, 32'h7FFF);
    set_ram(0, 16'h8000);
    do_frame(16'h0000, 24'd1, 8'd255, 8'd200, 1'b0);
    chk("t3_sat_neg", last_wdata, 32'h8000);
    do_frame(16'h1234, 24'd2, 8'd100, 8'd77, 1'b1);
    chk("t3_bypass_dac", last_dac, 32'h1234);

    // Buffer wrap and delay clamping.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      do_frame(16'(32'h9000 + 32'h0321 * k), 24'd0, 8'd64, 8'd96, 1'b0);
      if (k == 0) chk("t4_clamp_low_rd", last_rd_addr, BASE + 24'd14);
    end
    chk("t4_wrap_wr_addr", last_wr_addr, BASE + 24'd2);
    do_reset();
    do_frame(16'h4567, 24'd20, 8'd32, 8'd50, 1'b0);
    chk("t4_clamp_high_rd", last_rd_addr, BASE + 24'd2);

    // Overrun: step during RD.
    begin
      int dc0;
      dc0 = dac_cnt;
      chk("t5_overrun_clear", {31'd0, overrun}, 32'd0);
      start_frame(16'hA000, 24'd2, 8'd10, 8'd20, 1'b0);
      wait_ram(1'b0);
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      chk("t5_overrun_set", {31'd0, overrun}, 32'd1);
      wait_idle();
      repeat (5) @(posedge clk);
      #1;
      chk("t5_no_extra_frame", {31'd0, busy}, 32'd0);
      chk("t5_one_dac", dac_cnt - dc0, 32'd1);
      do_frame(16'h3333, 24'd4, 8'd0, 8'd0, 1'b0);
      chk("t5_overrun_sticky", {31'd0, overrun}, 32'd1);
      do_reset();
      chk("t5_overrun_reset", {31'd0, overrun}, 32'd0);
    end

    // Reset in the middle of the RAM write.
    do_frame(16'h5555, 24'd1, 8'd0, 8'd0, 1'b0);
    start_frame(16'h6666, 24'd1, 8'd0, 8'd0, 1'b0);
    wait_ram(1'b1);
    nrst = 1'b0;
    @(posedge clk); #1;
    chk("t6_busy_after_rst", {31'd0, busy}, 32'd0);
    chk("t6_ram_req_after_rst", {31'd0, ram_req}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    flush_model(1'b1);
    do_frame(16'h8765, 24'd1, 8'd0, 8'd0, 1'b0);
    chk("t6_wr_addr_restart", last_wr_addr, BASE);
    chk("t6_dac_restart", last_dac, 32'h8765);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
